add14p_msb: RTL and testbench
=============================

ADD14P_MSB -- requirements
Module: add14p_msb

Interface
REQ-001 SHALL have parameter WIDTH, default 7, meaning half-word width; total sum width is 2*WIDTH (14 at default).
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock for all registers.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port a_msb, input, WIDTH, the upper half of operand A, presented in the same cycle as the lower half goes to the upstream LSB carry-save stage.
REQ-005 SHALL have port b_msb, input, WIDTH, the upper half of operand B, with the same timing as a_msb.
REQ-006 SHALL have port vin, input, 1, operand-valid, with the same timing as a_msb.
REQ-007 SHALL have port s_lsb, input, WIDTH, the registered LSB sum from the upstream stage, arriving one cycle after a_msb.
REQ-008 SHALL have port c_lsb, input, 1, the registered LSB carry from the upstream stage, with the same timing as s_lsb.
REQ-009 SHALL have port clr_ovf, input, 1, synchronous clear of the sticky overflow flag.
REQ-010 SHALL have port sum, output, 2*WIDTH, the full registered sum.
REQ-011 SHALL have port cout, output, 1, the registered carry out of the MSB half.
REQ-012 SHALL have port vout, output, 1, result-valid.
REQ-013 SHALL have port ovf, output, 1, the sticky unsigned overflow flag.
REQ-014 SHALL have port count, output, 8, the number of valid results produced, modulo 256.

Function
REQ-015 Stage 1 SHALL register a_msb, b_msb and vin every clock into alignment registers (a_d, b_d, v_d), so they line up with s_lsb/c_lsb.
REQ-016 Stage 2 SHALL compute a_d + b_d + c_lsb at (WIDTH+1) bits, unsigned.
REQ-017 Stage 2 SHALL register sum[2*WIDTH-1:WIDTH] from the low WIDTH bits of that result.
REQ-018 Stage 2 SHALL register cout from bit WIDTH of that result.
REQ-019 Stage 2 SHALL register sum[WIDTH-1:0] from s_lsb.
REQ-020 Stage 2 SHALL register vout from v_d.
REQ-021 Latency SHALL be exactly 2 clocks: operands with vin=1 at edge N produce sum/cout with vout=1 after edge N+2.
REQ-022 Throughput SHALL be one operand pair per clock with no stalls; the pipeline registers SHALL update every clock regardless of vin.
REQ-023 sum and cout SHALL be don't-care when vout=0, but SHALL remain deterministic (they reflect the pipeline contents).
REQ-024 ovf SHALL be set on an edge where stage-2 cout and v_d are both 1.
REQ-025 ovf SHALL be cleared on an edge where clr_ovf=1 and the set condition is false.
REQ-026 When the set condition and clr_ovf=1 occur on the same edge, set SHALL win and ovf SHALL be 1.
REQ-027 ovf SHALL hold its value otherwise.
REQ-028 count SHALL increment by 1 on each edge where v_d=1, i.e. in the same edge vout is asserted.
REQ-029 count SHALL wrap from 255 to 0 without any flag.
REQ-030 Carry propagation SHALL be limited to one WIDTH+1-bit adder per stage; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-031 While reset=1, all registers (a_d, b_d, v_d, sum, cout, vout, ovf, count) SHALL be 0 asynchronously.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight operands; no vout=1 pulse SHALL appear for operands accepted before reset.
REQ-033 After reset deasserts, the first vout=1 SHALL occur 2 edges after the first vin=1.

Verification
REQ-034 Bench SHALL drive A=0x0155, B=0x0AAA (upstream s_lsb=0x7F, c_lsb=0) -> sum=0x0BFF, cout=0, vout=1 two clocks later.
REQ-035 Bench SHALL drive A=0x3FFF, B=0x0001 -> sum=0x0000, cout=1, ovf=1 from the following cycle, count increments by 1.
REQ-036 Bench SHALL drive back-to-back vin=1 for 300 random pairs against a reference 14-bit adder -> every result matches in order, and count=300 mod 256=44.
REQ-037 Bench SHALL assert clr_ovf in the same cycle as an overflowing result -> ovf stays 1; clr_ovf next cycle with no overflow -> ovf=0.
REQ-038 Bench SHALL assert reset one cycle after vin=1 -> all outputs 0 immediately, and no vout pulse after release.
REQ-039 Bench SHALL drive the pattern vin=1,0,1 -> vout=1,0,1 delayed by exactly 2 clocks.

Source files
------------

// File: rtl/add14p_msb_if.sv
// ============================================================================
// Module   : add14p_msb_if
// Purpose  : Operand, upstream-LSB and result bundle for the MSB adder stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add14p_msb_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0]   a_msb;
  logic [WIDTH-1:0]   b_msb;
  logic               vin;
  logic [WIDTH-1:0]   s_lsb;
  logic               c_lsb;
  logic               clr_ovf;
  logic [2*WIDTH-1:0] sum;
  logic               cout;
  logic               vout;
  logic               ovf;
  logic [7:0]         count;

  modport master (
    output a_msb, b_msb, vin, s_lsb, c_lsb, clr_ovf,
    input  sum, cout, vout, ovf, count
  );

  modport slave (
    input  a_msb, b_msb, vin, s_lsb, c_lsb, clr_ovf,
    output sum, cout, vout, ovf, count
  );
endinterface

`default_nettype wire

// File: rtl/add14p_msb.sv
// ============================================================================
// Module   : add14p_msb
// Purpose  : Upper-half stage of a two-stage carry-save adder pipeline with
//            sticky unsigned overflow and a result counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add14p_msb #(
  parameter int WIDTH = 7
) (
  input  wire logic     clock,
  input  wire logic     reset,
  add14p_msb_if.slave   bus
);

  logic [WIDTH-1:0]   r_a_d;
  logic [WIDTH-1:0]   r_b_d;
  logic               r_v_d;
  logic [2*WIDTH-1:0] r_sum;
  logic               r_cout;
  logic               r_vout;
  logic               r_ovf;
  logic [7:0]         r_count;

  logic [WIDTH:0]     w_msb_add;
  logic               w_ovf_set;

  // Upper half waits one cycle so it meets the registered carry from below.
  assign w_msb_add = {1'b0, r_a_d} + {1'b0, r_b_d} + {{WIDTH{1'b0}}, bus.c_lsb};
  assign w_ovf_set = w_msb_add[WIDTH] & r_v_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_d   <= '0;
      r_b_d   <= '0;
      r_v_d   <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_vout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      r_a_d  <= bus.a_msb;
      r_b_d  <= bus.b_msb;
      r_v_d  <= bus.vin;
      r_sum  <= {w_msb_add[WIDTH-1:0], bus.s_lsb};
      r_cout <= w_msb_add[WIDTH];
      r_vout <= r_v_d;
      // A new overflow outranks a simultaneous clear so it is never lost.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_ovf <= 1'b0;
      end
      if (r_v_d) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;
  assign bus.vout  = r_vout;
  assign bus.ovf   = r_ovf;
  assign bus.count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_add14p_msb.sv
// ============================================================================
// Module   : tb_add14p_msb
// Purpose  : Directed and random self-checking bench for add14p_msb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add14p_msb;

  logic clock;
  logic reset;

  add14p_msb_if #(.WIDTH(7)) bus ();

  add14p_msb #(.WIDTH(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Upstream LSB stage model: result of the previous operand pair.
  logic [6:0] lsb_s = '0;
  logic       lsb_c = 1'b0;

  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    logic [13:0] sum;
    logic        cout;
    logic        ovf;
    logic [7:0]  count;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [13:0] a, input logic [13:0] b, input logic v, input logic clr);
    bus.s_lsb   = lsb_s;
    bus.c_lsb   = lsb_c;
    bus.a_msb   = a[13:7];
    bus.b_msb   = b[13:7];
    bus.vin     = v;
    bus.clr_ovf = clr;
    {lsb_c, lsb_s} = {1'b0, a[6:0]} + {1'b0, b[6:0]};
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [13:0] ra, rb;
    logic [14:0] exp_q [$];
    logic [14:0] e;
    logic        exp_ovf;
    logic        pat_v [5];
    logic        pat_o [5];

    vecs[0] = '{14'h0155, 14'h0AAA, 14'h0BFF, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{14'h007F, 14'h0001, 14'h0080, 1'b0, 1'b0, 8'd2};
    vecs[2] = '{14'h1234, 14'h0DCB, 14'h1FFF, 1'b0, 1'b0, 8'd3};
    vecs[3] = '{14'h3FFF, 14'h0001, 14'h0000, 1'b1, 1'b1, 8'd4};
    vecs[4] = '{14'h2000, 14'h2000, 14'h0000, 1'b1, 1'b1, 8'd5};
    vecs[5] = '{14'h3F80, 14'h0080, 14'h0000, 1'b1, 1'b1, 8'd6};
    pat_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    pat_o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    bus.a_msb = '0; bus.b_msb = '0; bus.vin = 1'b0;
    bus.s_lsb = '0; bus.c_lsb = 1'b0; bus.clr_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset sum",   32'(bus.sum),   32'h0);
    check("reset cout",  32'(bus.cout),  32'h0);
    check("reset vout",  32'(bus.vout),  32'h0);
    check("reset ovf",   32'(bus.ovf),   32'h0);
    check("reset count", 32'(bus.count), 32'h0);
    reset = 1'b0;

    // Directed vectors: one operand, then an idle cycle to see the result.
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      check($sformatf("vec%0d early vout", i), 32'(bus.vout), 32'h0);
      step(14'h0, 14'h0, 1'b0, 1'b0);
      check($sformatf("vec%0d vout", i),  32'(bus.vout),  32'h1);
      check($sformatf("vec%0d sum", i),   32'(bus.sum),   32'(vecs[i].sum));
      check($sformatf("vec%0d cout", i),  32'(bus.cout),  32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i),   32'(bus.ovf),   32'(vecs[i].ovf));
      check($sformatf("vec%0d count", i), 32'(bus.count), 32'(vecs[i].count));
      step(14'h0, 14'h0, 1'b0, 1'b0);
      check($sformatf("vec%0d idle vout", i), 32'(bus.vout), 32'h0);
    end

    // Back-to-back random stream against a plain 14-bit adder.
    do_reset();
    exp_ovf = 1'b0;
    for (int i = 0; i <= 300; i++) begin
      if (i < 300) begin
        ra = 14'($urandom_range(0, 16383));
        rb = 14'($urandom_range(0, 16383));
        exp_q.push_back({1'b0, ra} + {1'b0, rb});
        step(ra, rb, 1'b1, 1'b0);
      end else begin
        step(14'h0, 14'h0, 1'b0, 1'b0);
      end
      if (i > 0) begin
        e = exp_q.pop_front();
        exp_ovf = exp_ovf | e[14];
        check($sformatf("rnd%0d vout", i), 32'(bus.vout), 32'h1);
        check($sformatf("rnd%0d sum", i),  32'(bus.sum),  32'(e[13:0]));
        check($sformatf("rnd%0d cout", i), 32'(bus.cout), 32'(e[14]));
        check($sformatf("rnd%0d ovf", i),  32'(bus.ovf),  32'(exp_ovf));
      end
    end
    check("rnd count", 32'(bus.count), 32'd44);

    // Clear racing an overflow: set wins, then the clear takes effect.
    do_reset();
    step(14'h3FFF, 14'h0001, 1'b1, 1'b0);
    step(14'h0, 14'h0, 1'b0, 1'b1);
    check("clr race ovf", 32'(bus.ovf), 32'h1);
    step(14'h0, 14'h0, 1'b0, 1'b1);
    check("clr next ovf", 32'(bus.ovf), 32'h0);

    // Mid-stream asynchronous reset discards the in-flight operand.
    step(14'h3FFF, 14'h0001, 1'b1, 1'b0);
    step(14'h0155, 14'h0AAA, 1'b1, 1'b0);
    check("pre-rst vout", 32'(bus.vout), 32'h1);
    check("pre-rst ovf",  32'(bus.ovf),  32'h1);
    bus.vin = 1'b0;
    reset = 1'b1;
    #1;
    check("async rst vout",  32'(bus.vout),  32'h0);
    check("async rst cout",  32'(bus.cout),  32'h0);
    check("async rst ovf",   32'(bus.ovf),   32'h0);
    check("async rst count", 32'(bus.count), 32'h0);
    check("async rst sum",   32'(bus.sum),   32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(14'h0, 14'h0, 1'b0, 1'b0);
      check($sformatf("post-rst vout%0d", i), 32'(bus.vout), 32'h0);
    end
    check("post-rst count", 32'(bus.count), 32'h0);

    // First operand after reset appears exactly two edges later.
    step(14'h0155, 14'h0AAA, 1'b1, 1'b0);
    check("first vout early", 32'(bus.vout), 32'h0);
    step(14'h0, 14'h0, 1'b0, 1'b0);
    check("first vout",  32'(bus.vout),  32'h1);
    check("first sum",   32'(bus.sum),   32'h0BFF);
    check("first count", 32'(bus.count), 32'h1);

    // Valid pattern 1,0,1 shows up two clocks later.
    for (int i = 0; i < 5; i++) begin
      step(14'h0001, 14'h0002, pat_v[i], 1'b0);
      check($sformatf("pattern vout%0d", i), 32'(bus.vout), 32'(pat_o[i]));
    end
    check("pattern count", 32'(bus.count), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
